batch_gradient_reducer: RTL and testbench
=========================================

BATCH_GRADIENT_REDUCER -- requirements
Module: batch_gradient_reducer

Interface
REQ-001 SHALL have parameter LANES, default 16: number of DATA_W lanes per beat; power of two, 2..64.
REQ-002 SHALL have parameter DATA_W, default 32: signed two's-complement fixed-point lane width.
REQ-003 SHALL have parameter ACC_W, default 48: signed batch accumulator width; ACC_W >= DATA_W + log2(LANES).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous reset, active-low.
REQ-006 SHALL have port s_axis_rx_data_TDATA, input, LANES*DATA_W: lane k at bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port s_axis_rx_data_TKEEP, input, LANES: per-lane enable; a cleared bit contributes zero.
REQ-008 SHALL have ports s_axis_rx_data_TVALID (input), TLAST (input, last beat of batch) and TREADY (output), 1 bit each.
REQ-009 SHALL have port mode, input, 1: 0 = SUM, 1 = MEAN.
REQ-010 SHALL have port n_recip, input, 32: unsigned Q0.32 reciprocal of batch size N.
REQ-011 SHALL have port batch_gradient_TDATA, output, DATA_W: reduced result.
REQ-012 SHALL have port batch_gradient_TCOUNT, output, 16: number of beats in the batch, saturating at 65535.
REQ-013 SHALL have port batch_gradient_TSAT, output, 1: accumulator or output saturation occurred in the batch.
REQ-014 SHALL have ports batch_gradient_TVALID (output) and batch_gradient_TREADY (input), 1 bit each.

Function
REQ-015 Beat acceptance SHALL occur only when TVALID && TREADY; TREADY = !batch_gradient_TVALID || batch_gradient_TREADY, with no other combinational path.
REQ-016 The pipeline SHALL advance only while the enable (REQ-015 TREADY term) is high; while it is low, every stage SHALL hold its data, valid, last and first flags.
REQ-017 The adder tree SHALL have log2(LANES) registered stages, each summing pairs sign-extended by one bit, with no saturation inside the tree.
REQ-018 The accumulate stage (1 register) SHALL load the tree sum when the beat is first-of-batch, otherwise add it; the result SHALL saturate to the ACC_W signed range and set a sticky saturation flag.
REQ-019 First-of-batch SHALL be true for the first beat after reset and for the first beat after any TLAST beat; a single beat with TLAST is a complete batch.
REQ-020 mode and n_recip SHALL be captured on the first beat of a batch and used for the whole batch.
REQ-021 The scale stage (1 register, fires on last beat) SHALL output acc[DATA_W-1:0] with saturation in SUM mode, and (acc * n_recip) >>> 32, rounded toward negative infinity and then saturated, in MEAN mode.
REQ-022 Saturation SHALL clamp to 2^(DATA_W-1)-1 or -2^(DATA_W-1); TSAT = accumulator flag OR output clamp.
REQ-023 Latency from TLAST beat accepted to batch_gradient_TVALID high SHALL be log2(LANES)+2 enabled cycles.
REQ-024 batch_gradient_TVALID SHALL stay high with TDATA, TCOUNT and TSAT stable until batch_gradient_TREADY is high.
REQ-025 Back-to-back batches SHALL be accepted with no bubble; throughput SHALL be one beat per cycle while the output is not stalled.
REQ-026 Input bubbles (TVALID low) SHALL NOT alter the accumulator or the beat count.

Reset
REQ-027 While rst = 0 at a clock edge, all valid flags, accumulators, counters and sticky flags SHALL clear and the first-of-batch flag SHALL set.
REQ-028 During reset, batch_gradient_TVALID = 0, TDATA = 0, TCOUNT = 0 and TSAT = 0; TREADY = 1 from the first cycle after release.
REQ-029 Reset mid-batch or with the output stalled SHALL discard all in-flight beats and the pending result.

Structure
REQ-030 A shared package SHALL hold the LANES-to-stage-count function (clog2), the SUM/MEAN mode constants and the saturate function.
REQ-031 A single sub-module, grad_adder_tree (parametrised on LANES, DATA_W, with enable, valid, last and first sideband), is natural; accumulate and scale stay in the top level.

Verification (LANES=16, DATA_W=32, ACC_W=48)
REQ-032 Stimulus: one beat, all lanes 1, TKEEP=FFFF, TLAST, SUM. Response: TDATA=16, TCOUNT=1, TSAT=0, valid 6 cycles later.
REQ-033 Stimulus: 4 beats, lanes 2, TKEEP=00FF, MEAN, n_recip=0x40000000. Response: TDATA=16, TCOUNT=4.
REQ-034 Stimulus: 3 beats, all lanes 0x7FFFFFFF, SUM. Response: TDATA=0x7FFFFFFF, TSAT=1.
REQ-035 Stimulus: two back-to-back 1-beat batches, values 1 then -1, with batch_gradient_TREADY=0 for 10 cycles. Response: TREADY drops; results 16 then -16 delivered in order, no loss.
REQ-036 Stimulus: rst=0 for one cycle mid-batch, then a new 2-beat batch of lanes 3. Response: TDATA=96, TCOUNT=2, no stale output.

Source files
------------

// File: rtl/batch_gradient_reducer_pkg.sv
// Shared constants and helpers for the batch gradient reducer: stage count,
// reduction mode encodings and signed saturation on a wide intermediate.
package batch_gradient_reducer_pkg;

    localparam logic MODE_SUM  = 1'b0;
    localparam logic MODE_MEAN = 1'b1;

    // Ceiling log2 of the lane count; equals the number of adder-tree stages.
    function automatic int stage_count(input int lanes);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < lanes) n = i + 1;
        end
        return n;
    endfunction

    function automatic logic signed [127:0] saturate(input logic signed [127:0] v, input int w);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic saturates(input logic signed [127:0] v, input int w);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/batch_gradient_reducer_adder_tree.sv
// Pipelined pairwise adder tree: one register stage per halving, each stage one
// bit wider than the last, with valid/last/first/tag sideband carried alongside.
module grad_adder_tree
    import batch_gradient_reducer_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 1,
    localparam int STAGES = stage_count(LANES),
    localparam int SUM_W  = DATA_W + STAGES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic                     in_first,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [LANES*DATA_W-1:0]  data,
    input  logic [LANES-1:0]         keep,
    output logic                     out_valid,
    output logic                     out_last,
    output logic                     out_first,
    output logic [TAG_W-1:0]         out_tag,
    output logic signed [SUM_W-1:0]  sum
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] last_q;
    logic [STAGES-1:0] first_q;
    logic [TAG_W-1:0]  tag_q [STAGES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            last_q  <= '0;
            first_q <= '0;
            for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
        end else if (en) begin
            valid_q[0] <= in_valid;
            last_q[0]  <= in_last;
            first_q[0] <= in_first;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
                first_q[i] <= first_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int OW = DATA_W + s + 1;
        localparam int N  = LANES >> (s + 1);
        logic signed [OW-2:0] src  [2*N];
        logic signed [OW-1:0] node [N];

        if (s == 0) begin : g_src
            // Masked lanes enter the tree as zero.
            always_comb begin
                for (int i = 0; i < 2 * N; i++) begin
                    src[i] = keep[i] ? data[i*DATA_W +: DATA_W] : '0;
                end
            end
        end else begin : g_src
            always_comb begin
                for (int i = 0; i < 2 * N; i++) begin
                    src[i] = g_stage[s-1].node[i];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                for (int i = 0; i < N; i++) begin
                    node[i] <= OW'(src[2*i]) + OW'(src[2*i+1]);
                end
            end
        end
    end

    assign sum       = g_stage[STAGES-1].node[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_last  = last_q[STAGES-1];
    assign out_first = first_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: rtl/batch_gradient_reducer.sv
// Reduces batches of multi-lane gradient beats to one saturated scalar (sum or
// mean). Tree, accumulate and scale stages all advance on a single enable.
module batch_gradient_reducer
    import batch_gradient_reducer_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] s_axis_rx_data_TDATA,
    input  logic [LANES-1:0]        s_axis_rx_data_TKEEP,
    input  logic                    s_axis_rx_data_TVALID,
    input  logic                    s_axis_rx_data_TLAST,
    output logic                    s_axis_rx_data_TREADY,
    input  logic                    mode,
    input  logic [31:0]             n_recip,
    output logic [DATA_W-1:0]       batch_gradient_TDATA,
    output logic [15:0]             batch_gradient_TCOUNT,
    output logic                    batch_gradient_TSAT,
    output logic                    batch_gradient_TVALID,
    input  logic                    batch_gradient_TREADY
);

    localparam int STAGES = stage_count(LANES);
    localparam int SUM_W  = DATA_W + STAGES;
    localparam int TAG_W  = 33;

    // Valid/ready: a beat transfers on a rising edge where TVALID && TREADY.
    // TREADY is the pipeline enable: the result register is empty or draining.
    logic en;
    assign en = !batch_gradient_TVALID || batch_gradient_TREADY;
    assign s_axis_rx_data_TREADY = en;

    logic first_q;
    always_ff @(posedge clk) begin
        if (!rst) first_q <= 1'b1;
        else if (en && s_axis_rx_data_TVALID) first_q <= s_axis_rx_data_TLAST;
    end

    logic                    tree_valid;
    logic                    tree_last;
    logic                    tree_first;
    logic [TAG_W-1:0]        tree_tag;
    logic signed [SUM_W-1:0] tree_sum;

    // mode and n_recip ride the tree as a tag so the next batch cannot disturb them.
    grad_adder_tree #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (s_axis_rx_data_TVALID),
        .in_last   (s_axis_rx_data_TLAST),
        .in_first  (first_q),
        .in_tag    ({mode, n_recip}),
        .data      (s_axis_rx_data_TDATA),
        .keep      (s_axis_rx_data_TKEEP),
        .out_valid (tree_valid),
        .out_last  (tree_last),
        .out_first (tree_first),
        .out_tag   (tree_tag),
        .sum       (tree_sum)
    );

    logic                    acc_valid;
    logic                    acc_last;
    logic signed [ACC_W-1:0] acc_q;
    logic                    acc_sat;
    logic [15:0]             cnt_q;
    logic                    mode_q;
    logic [31:0]             recip_q;

    logic signed [ACC_W:0]   acc_next;
    logic signed [127:0]     acc_wide;

    always_comb begin
        acc_next = (tree_first ? '0 : (ACC_W+1)'(acc_q)) + (ACC_W+1)'(tree_sum);
        acc_wide = 128'(acc_next);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_valid <= 1'b0;
            acc_last  <= 1'b0;
            acc_q     <= '0;
            acc_sat   <= 1'b0;
            cnt_q     <= '0;
            mode_q    <= MODE_SUM;
            recip_q   <= '0;
        end else if (en) begin
            acc_valid <= tree_valid;
            acc_last  <= tree_last;
            if (tree_valid) begin
                acc_q   <= ACC_W'(saturate(acc_wide, ACC_W));
                acc_sat <= (tree_first ? 1'b0 : acc_sat) | saturates(acc_wide, ACC_W);
                if (tree_first) begin
                    cnt_q   <= 16'd1;
                    mode_q  <= tree_tag[32];
                    recip_q <= tree_tag[31:0];
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

    // Arithmetic shift of the signed product floors toward negative infinity.
    logic signed [ACC_W+32:0] prod;
    logic signed [127:0]      scaled_wide;

    always_comb begin
        prod        = acc_q * $signed({1'b0, recip_q});
        scaled_wide = (mode_q == MODE_MEAN) ? 128'(prod >>> 32) : 128'(acc_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            batch_gradient_TVALID <= 1'b0;
            batch_gradient_TDATA  <= '0;
            batch_gradient_TCOUNT <= '0;
            batch_gradient_TSAT   <= 1'b0;
        end else if (en) begin
            batch_gradient_TVALID <= acc_valid && acc_last;
            if (acc_valid && acc_last) begin
                batch_gradient_TDATA  <= DATA_W'(saturate(scaled_wide, DATA_W));
                batch_gradient_TCOUNT <= cnt_q;
                batch_gradient_TSAT   <= acc_sat | saturates(scaled_wide, DATA_W);
            end
        end
    end

endmodule

// File: tb/tb_batch_gradient_reducer.sv
// Directed bench for batch_gradient_reducer at LANES=16, DATA_W=32, ACC_W=48.
module tb_batch_gradient_reducer;
    localparam int LANES  = 16;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 48;

    logic                    clk;
    logic                    rst;
    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES-1:0]        tkeep;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;
    logic                    mode;
    logic [31:0]             n_recip;
    logic [DATA_W-1:0]       out_data;
    logic [15:0]             out_count;
    logic                    out_sat;
    logic                    out_valid;
    logic                    out_ready;

    int total = 0;
    int bad   = 0;

    batch_gradient_reducer #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .s_axis_rx_data_TDATA  (tdata),
        .s_axis_rx_data_TKEEP  (tkeep),
        .s_axis_rx_data_TVALID (tvalid),
        .s_axis_rx_data_TLAST  (tlast),
        .s_axis_rx_data_TREADY (tready),
        .mode                  (mode),
        .n_recip               (n_recip),
        .batch_gradient_TDATA  (out_data),
        .batch_gradient_TCOUNT (out_count),
        .batch_gradient_TSAT   (out_sat),
        .batch_gradient_TVALID (out_valid),
        .batch_gradient_TREADY (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send_beat(input logic [31:0] lane, input logic [15:0] keep, input logic last,
                             input logic md, input logic [31:0] rc);
        bit ok;
        tdata   = {LANES{lane}};
        tkeep   = keep;
        tlast   = last;
        mode    = md;
        n_recip = rc;
        tvalid  = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (tready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL beat_accept: tready=%0b required 1 within 100 cycles", tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        out_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %0h want 0", out_data); end
        total++; if (out_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", out_count); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %0b want 0", out_sat); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (tready !== 1'b1) begin bad++; $display("FAIL reset_tready: got %0b want 1", tready); end
    endtask

    task automatic test_single_sum();
        int cyc;
        send_beat(32'd1, 16'hFFFF, 1'b1, 1'b0, 32'd0);
        idle();
        wait_valid(cyc);
        total++; if (cyc != 6) begin bad++; $display("FAIL single_latency: got %0d want 6", cyc); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        total++; if (out_data !== 32'd16) begin bad++; $display("FAIL single_data: got %0h want 10", out_data); end
        total++; if (out_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", out_count); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL single_sat: got %0b want 0", out_sat); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: valid=%0b want 0", out_valid); end
    endtask

    task automatic test_mean();
        int cyc;
        // Later beats carry a different mode/recip; the first beat's values must win.
        send_beat(32'd2, 16'h00FF, 1'b0, 1'b1, 32'h4000_0000);
        send_beat(32'd2, 16'h00FF, 1'b0, 1'b0, 32'd0);
        send_beat(32'd2, 16'h00FF, 1'b0, 1'b0, 32'd0);
        send_beat(32'd2, 16'h00FF, 1'b1, 1'b0, 32'd0);
        idle();
        wait_valid(cyc);
        total++; if (out_data !== 32'd16) begin bad++; $display("FAIL mean_data: got %0h want 10", out_data); end
        total++; if (out_count !== 16'd4) begin bad++; $display("FAIL mean_count: got %0d want 4", out_count); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL mean_sat: got %0b want 0", out_sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        int cyc;
        for (int i = 0; i < 3; i++) send_beat(32'h7FFF_FFFF, 16'hFFFF, (i == 2), 1'b0, 32'd0);
        idle();
        wait_valid(cyc);
        total++; if (out_data !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_data: got %0h want 7fffffff", out_data); end
        total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL sat_flag: got %0b want 1", out_sat); end
        total++; if (out_count !== 16'd3) begin bad++; $display("FAIL sat_count: got %0d want 3", out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_mean_floor();
        int cyc;
        // -1 * 0.5 = -0.5 floors to -1; the previous batch's sat flag must not leak.
        send_beat(32'hFFFF_FFFF, 16'h0001, 1'b1, 1'b1, 32'h8000_0000);
        idle();
        wait_valid(cyc);
        total++; if (out_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL floor_data: got %0h want ffffffff", out_data); end
        total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL floor_sat: got %0b want 0", out_sat); end
        @(posedge clk); #1;
    endtask

    task automatic test_bubbles();
        int cyc;
        send_beat(32'd4, 16'hFFFF, 1'b0, 1'b0, 32'd0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        send_beat(32'd4, 16'hFFFF, 1'b1, 1'b0, 32'd0);
        idle();
        wait_valid(cyc);
        total++; if (out_data !== 32'd128) begin bad++; $display("FAIL bubble_data: got %0h want 80", out_data); end
        total++; if (out_count !== 16'd2) begin bad++; $display("FAIL bubble_count: got %0d want 2", out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_throughput();
        int cyc;
        send_beat(32'd1, 16'hFFFF, 1'b1, 1'b0, 32'd0);
        send_beat(32'd2, 16'hFFFF, 1'b1, 1'b0, 32'd0);
        send_beat(32'd3, 16'hFFFF, 1'b1, 1'b0, 32'd0);
        idle();
        wait_valid(cyc);
        for (int i = 1; i <= 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'(16 * i)) begin
                bad++;
                $display("FAIL stream_%0d: valid=%0b data=%0h want valid=1 data=%0h", i, out_valid, out_data, 16 * i);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        int got;
        out_ready = 1'b0;
        send_beat(32'd1, 16'hFFFF, 1'b1, 1'b0, 32'd0);
        exp_q.push_back(32'd16);
        send_beat(32'hFFFF_FFFF, 16'hFFFF, 1'b1, 1'b0, 32'd0);
        exp_q.push_back(32'hFFFF_FFF0);
        idle();
        repeat (10) @(posedge clk);
        #1;
        total++; if (tready !== 1'b0) begin bad++; $display("FAIL stall_tready: got %0b want 0", tready); end
        total++; if (out_valid !== 1'b1 || out_data !== 32'd16) begin
            bad++; $display("FAIL stall_hold: valid=%0b data=%0h want valid=1 data=10", out_valid, out_data);
        end
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            if (out_valid) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                got++;
                total++;
                if (out_data !== e) begin bad++; $display("FAIL b2b_result_%0d: got %0h want %0h", got, out_data, e); end
            end
            @(posedge clk); #1;
        end
        total++; if (got != 2) begin bad++; $display("FAIL b2b_count: got %0d results want 2", got); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        send_beat(32'd5, 16'hFFFF, 1'b0, 1'b0, 32'd0);
        idle();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
        send_beat(32'd3, 16'hFFFF, 1'b0, 1'b0, 32'd0);
        send_beat(32'd3, 16'hFFFF, 1'b1, 1'b0, 32'd0);
        idle();
        wait_valid(cyc);
        total++; if (out_data !== 32'd96) begin bad++; $display("FAIL midrst_data: got %0h want 60", out_data); end
        total++; if (out_count !== 16'd2) begin bad++; $display("FAIL midrst_count: got %0d want 2", out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_stalled();
        int cyc;
        int seen;
        out_ready = 1'b0;
        send_beat(32'd1, 16'hFFFF, 1'b1, 1'b0, 32'd0);
        idle();
        wait_valid(cyc);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stlrst_pending: got %0b want 1", out_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin
            bad++; $display("FAIL stlrst_cleared: valid=%0b data=%0h want 0 0", out_valid, out_data);
        end
        out_ready = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL stlrst_stale: %0d valid cycles want 0", seen); end
    endtask

    initial begin
        rst = 1'b0;
        tdata = '0;
        tkeep = '0;
        tvalid = 1'b0;
        tlast = 1'b0;
        mode = 1'b0;
        n_recip = '0;
        out_ready = 1'b1;
        test_reset();
        test_single_sum();
        test_mean();
        test_saturate();
        test_mean_floor();
        test_bubbles();
        test_throughput();
        test_back_to_back();
        test_reset_mid();
        test_reset_stalled();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
